// File: rtl/sbus_tx.sv
// sbus_tx: S.Bus frame builder and serial transmitter.
// Accepts 16 x 11-bit channels plus 4 flags, sends the 25-byte frame
// (0x0F, 22 channel bytes, flag byte, 0x00) as 8E2 serial at BIT_RATE.
// After each frame it holds the line idle for GAP_BITS bit times.
module sbus_tx #(
    parameter int unsigned CLK_HZ   = 50000000,
    parameter int unsigned BIT_RATE = 100000,
    parameter int unsigned GAP_BITS = 400,
    parameter bit          INVERT   = 1'b0
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         tx_en,
    input  logic         frame_valid,
    output logic         frame_ready,
    input  logic [175:0] ch_data,
    input  logic [3:0]   flags,
    output logic         frame_done,
    output logic         sbus_txd
);

    localparam int unsigned CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
    localparam int CNT_W = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
    localparam int GAP_W = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_BITS - 1);
    localparam logic [4:0] LAST_BYTE = 5'd24;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_GAP
    } state_t;

    state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]   bit_q, bit_d;
    logic         stop_q, stop_d;
    logic [4:0]   byte_q, byte_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [175:0] ch_q;
    logic [3:0]   flags_q;
    logic         load;
    logic         line_d;
    logic         txd_q;
    logic         done_q, done_d;
    logic         bit_end;
    logic [7:0]   cur_byte;

    // Frame byte k: header, a contiguous LSB-first slice of the channel
    // bit stream, the flag byte, or the footer.
    function automatic logic [7:0] frame_byte(input logic [4:0] idx,
                                              input logic [175:0] ch,
                                              input logic [3:0] fl);
        int base;
        logic [7:0] b;
        b = 8'h00;
        if (idx == 5'd0) begin
            b = 8'h0F;
        end else if (idx <= 5'd22) begin
            base = 8 * (int'(idx) - 1);
            b = ch[base +: 8];
        end else if (idx == 5'd23) begin
            b = {4'b0000, fl};
        end
        return b;
    endfunction

    assign frame_ready = (state_q == S_IDLE) && tx_en && resetn;
    assign frame_done  = done_q;
    assign sbus_txd    = txd_q;
    assign cur_byte    = frame_byte(byte_q, ch_q, flags_q);
    assign bit_end     = (cnt_q == CNT_LAST);

    // Next-state logic: bit timing, byte sequencing and the line level
    // that the next cycle will present.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        byte_d  = byte_q;
        gap_d   = gap_q;
        done_d  = 1'b0;
        load    = 1'b0;
        line_d  = 1'b1;

        if (state_q != S_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (frame_valid && frame_ready) begin
                    state_d = S_START;
                    cnt_d   = '0;
                    bit_d   = '0;
                    stop_d  = 1'b0;
                    byte_d  = '0;
                    gap_d   = '0;
                    load    = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = S_PARITY;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    stop_d  = 1'b0;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (!stop_q) begin
                        stop_d = 1'b1;
                    end else if (byte_q == LAST_BYTE) begin
                        state_d = S_GAP;
                        gap_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_START;
                        byte_d  = byte_q + 5'd1;
                    end
                end
            end
            S_GAP: begin
                if (bit_end) begin
                    if (gap_q == GAP_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The byte index only changes on entry to START, so cur_byte is
        // already the right byte for any DATA or PARITY bit that follows.
        case (state_d)
            S_START:  line_d = 1'b0;
            S_DATA:   line_d = cur_byte[bit_d];
            S_PARITY: line_d = ^cur_byte;
            default:  line_d = 1'b1;
        endcase
    end

    // State, counters, shadow registers and the registered line output.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            byte_q  <= '0;
            gap_q   <= '0;
            ch_q    <= '0;
            flags_q <= '0;
            txd_q   <= 1'b1 ^ INVERT;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            byte_q  <= byte_d;
            gap_q   <= gap_d;
            txd_q   <= line_d ^ INVERT;
            done_q  <= done_d;
            if (load) begin
                ch_q    <= ch_data;
                flags_q <= flags;
            end
        end
    end

endmodule

// File: tb/tb_sbus_tx.sv
// tb_sbus_tx: directed bench for sbus_tx with shortened bit period and gap.
// A second instance with INVERT = 1 runs in lockstep on the same inputs.
module tb_sbus_tx;

    localparam int CLK_HZ    = 800;
    localparam int BIT_RATE  = 100;
    localparam int CPB       = 8;
    localparam int GAP_BITS  = 10;
    localparam int FRAME_CYC = 300 * CPB;
    localparam int GAP_CYC   = GAP_BITS * CPB;

    logic         clk;
    logic         resetn;
    logic         tx_en;
    logic         frame_valid;
    logic [175:0] ch_data;
    logic [3:0]   flags;
    logic         frame_ready, frame_done, sbus_txd;
    logic         frame_ready_n, frame_done_n, sbus_txd_n;

    int vectors;
    int miscompares;

    logic [7:0] exp_bytes [25];
    logic       exp_bits  [300];
    logic       rx_bits   [300];
    logic [7:0] rx_bytes  [25];

    sbus_tx #(.CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE), .GAP_BITS(GAP_BITS), .INVERT(1'b0)) dut (
        .clk(clk), .resetn(resetn), .tx_en(tx_en), .frame_valid(frame_valid),
        .frame_ready(frame_ready), .ch_data(ch_data), .flags(flags),
        .frame_done(frame_done), .sbus_txd(sbus_txd)
    );

    sbus_tx #(.CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE), .GAP_BITS(GAP_BITS), .INVERT(1'b1)) dut_inv (
        .clk(clk), .resetn(resetn), .tx_en(tx_en), .frame_valid(frame_valid),
        .frame_ready(frame_ready_n), .ch_data(ch_data), .flags(flags),
        .frame_done(frame_done_n), .sbus_txd(sbus_txd_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic build_expected(input logic [175:0] ch, input logic [3:0] fl);
        exp_bytes[0] = 8'h0F;
        for (int k = 1; k <= 22; k++) exp_bytes[k] = ch[8*(k-1) +: 8];
        exp_bytes[23] = {4'b0000, fl};
        exp_bytes[24] = 8'h00;
        for (int b = 0; b < 25; b++) begin
            exp_bits[b*12] = 1'b0;
            for (int i = 0; i < 8; i++) exp_bits[b*12+1+i] = exp_bytes[b][i];
            exp_bits[b*12+9]  = ^exp_bytes[b];
            exp_bits[b*12+10] = 1'b1;
            exp_bits[b*12+11] = 1'b1;
        end
    endtask

    task automatic start_frame(input logic [175:0] ch, input logic [3:0] fl);
        @(negedge clk);
        check("ready_before_hs", frame_ready, 1);
        check("ready_inv_before_hs", frame_ready_n, 1);
        frame_valid = 1'b1;
        ch_data     = ch;
        flags       = fl;
        build_expected(ch, fl);
        @(posedge clk);
        #1;
        frame_valid = 1'b0;
    endtask

    task automatic run_frame(input bit shadow_test, input bit drop_en);
        int bi;
        for (int k = 1; k <= FRAME_CYC; k++) begin
            @(negedge clk);
            bi = (k - 1) / CPB;
            check($sformatf("txd c%0d", k), sbus_txd, exp_bits[bi]);
            check($sformatf("txd_inv c%0d", k), sbus_txd_n, !exp_bits[bi]);
            check("done_in_frame", frame_done, 0);
            check("ready_in_frame", frame_ready, 0);
            if ((k - 1) % CPB == CPB / 2) rx_bits[bi] = sbus_txd;
            if (shadow_test && k == 3) begin
                ch_data = '1;
                flags   = 4'hF;
            end
            if (drop_en && k == 100) tx_en = 1'b0;
        end
        for (int b = 0; b < 25; b++)
            for (int i = 0; i < 8; i++) rx_bytes[b][i] = rx_bits[b*12+1+i];
        @(negedge clk);
        check("done_pulse", frame_done, 1);
        check("done_pulse_inv", frame_done_n, 1);
        check("txd_gap_first", sbus_txd, 1);
        check("txd_inv_gap_first", sbus_txd_n, 0);
        check("ready_gap_first", frame_ready, 0);
        for (int k = 2; k <= GAP_CYC; k++) begin
            @(negedge clk);
            check("done_in_gap", frame_done, 0);
            check("txd_in_gap", sbus_txd, 1);
            check("ready_in_gap", frame_ready, 0);
        end
        @(negedge clk);
        check("ready_after_gap", frame_ready, drop_en ? 0 : 1);
    endtask

    initial begin
        logic [175:0] ch;
        logic [3:0]   fl;
        int bi;
        vectors     = 0;
        miscompares = 0;
        clk         = 1'b0;
        resetn      = 1'b0;
        tx_en       = 1'b1;
        frame_valid = 1'b0;
        ch_data     = '0;
        flags       = '0;

        // Reset held low for two edges
        repeat (2) @(negedge clk);
        check("rst_txd", sbus_txd, 1);
        check("rst_txd_inv", sbus_txd_n, 0);
        check("rst_done", frame_done, 0);
        check("rst_ready", frame_ready, 0);
        resetn = 1'b1;
        @(negedge clk);
        check("ready_after_rst", frame_ready, 1);
        check("txd_after_rst", sbus_txd, 1);

        // Single frame: ch0 = 0x7FF
        start_frame(176'h7FF, 4'h0);
        run_frame(1'b0, 1'b0);
        check("b0", rx_bytes[0], 8'h0F);
        check("b1", rx_bytes[1], 8'hFF);
        check("b2", rx_bytes[2], 8'h07);
        for (int b = 3; b < 25; b++) check($sformatf("b%0d_zero", b), rx_bytes[b], 8'h00);
        check("par_b0", rx_bits[9], 0);
        check("par_b1", rx_bits[21], 0);
        check("par_b2", rx_bits[33], 1);
        for (int b = 0; b < 25; b++) begin
            check("stop1", rx_bits[b*12+10], 1);
            check("stop2", rx_bits[b*12+11], 1);
        end

        // Flags and shadowing: ch0 = 0x155, ch1 = 0x2AA, inputs overwritten mid-frame
        ch = '0;
        ch[10:0]  = 11'h155;
        ch[21:11] = 11'h2AA;
        start_frame(ch, 4'b1010);
        run_frame(1'b1, 1'b0);
        check("sh_b1", rx_bytes[1], 8'h55);
        check("sh_b2", rx_bytes[2], 8'h51);
        check("sh_b3", rx_bytes[3], 8'h15);
        for (int b = 4; b <= 22; b++) check($sformatf("sh_b%0d", b), rx_bytes[b], 8'h00);
        check("sh_flags", rx_bytes[23], 8'h0A);
        check("sh_footer", rx_bytes[24], 8'h00);

        // Four frames of random channels
        for (int f = 0; f < 4; f++) begin
            for (int j = 0; j < 176; j++) ch[j] = 1'($urandom_range(0, 1));
            fl = 4'($urandom_range(0, 15));
            start_frame(ch, fl);
            run_frame(1'b0, 1'b0);
            for (int b = 0; b < 25; b++) check($sformatf("rnd%0d_b%0d", f, b), rx_bytes[b], exp_bytes[b]);
        end

        // tx_en dropped mid-frame: frame completes, ready held off
        start_frame(176'h3, 4'h5);
        run_frame(1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("ready_txen_low", frame_ready, 0);
            check("txd_txen_low", sbus_txd, 1);
        end
        tx_en = 1'b1;
        @(negedge clk);
        check("ready_txen_back", frame_ready, 1);

        // Reset mid-frame aborts the frame
        for (int j = 0; j < 176; j++) ch[j] = 1'($urandom_range(0, 1));
        start_frame(ch, 4'h3);
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            bi = (k - 1) / CPB;
            check("abort_txd", sbus_txd, exp_bits[bi]);
        end
        resetn = 1'b0;
        @(negedge clk);
        check("abort_txd_idle", sbus_txd, 1);
        check("abort_txd_inv_idle", sbus_txd_n, 0);
        check("abort_done", frame_done, 0);
        check("abort_ready", frame_ready, 0);
        @(negedge clk);
        resetn = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            check("post_abort_done", frame_done, 0);
            check("post_abort_txd", sbus_txd, 1);
        end
        check("post_abort_ready", frame_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sbus_tx.md
# sbus_tx

S.Bus frame encoder and serial transmitter, the transmit-side counterpart of the S.Bus receive path (100 kbit/s, 8 data bits, even parity, 2 stop bits). It takes 16 packed 11-bit channel values plus 4 flag bits through a valid/ready handshake. It builds the standard 25-byte frame: header 0x0F, 22 channel bytes, flag byte, footer 0x00. It then shifts the frame out LSB-first, followed by an enforced idle gap. It drives servo, bench-loopback and receiver-test paths from the same 50 MHz system clock.

## Interface

- CLK_HZ, 50000000, system clock frequency
- BIT_RATE, 100000, line bit rate; CYCLES_PER_BIT = CLK_HZ/BIT_RATE (500)
- GAP_BITS, 400, minimum idle bit times after each frame before the next is accepted (4 ms)
- INVERT, 0, 1 = drive logically inverted line (native S.Bus polarity)

Ports:

- clk  in  1  system clock
- resetn  in  1  reset; one clock; reset is synchronous and active-low
- tx_en  in  1  transmit enable; gates acceptance only
- frame_valid  in  1  frame request
- frame_ready  out  1  block can accept a frame
- ch_data  in  176  16 channels × 11 bits, ch0 at [10:0], ch15 at [175:165]
- flags  in  4  [0] ch17, [1] ch18, [2] frame_lost, [3] failsafe
- frame_done  out  1  one-cycle pulse after last stop bit of footer
- sbus_txd  out  1  serial line (idle = 1 before INVERT)

## Operation

- Handshake: transfer on a rising edge where frame_valid && frame_ready. ch_data and flags are captured into shadow registers; inputs are ignored until the next transfer.
- frame_ready = 1 only in IDLE with tx_en = 1.
- tx_en low in IDLE: frame_ready = 0. tx_en falling mid-frame: the current frame and gap complete normally.
- Frame bytes: B0 = 0x0F. Bk = shadow_ch[8(k-1)+7 : 8(k-1)] for k = 1..22, i.e. a contiguous LSB-first bit stream. B23 = {4'b0, flags}. B24 = 0x00.
- Per byte, 12 bit times: start 0, data[0..7] LSB first, parity = ^data (even), stop 1, stop 1. Bytes are sent back-to-back with no extra idle.
- FSM: IDLE → START → DATA (8 bits) → PARITY → STOP (2 bits) → START of next byte, or GAP after B24. GAP → IDLE after GAP_BITS bit times.
- Counters:
  - bit-period counter 0..CYCLES_PER_BIT-1, restarted at every bit boundary.
  - bit index 0..7.
  - stop index 0..1.
  - byte index 0..24.
  - gap counter 0..GAP_BITS-1, in bit periods.
- sbus_txd is registered: line value XOR INVERT. It is idle (1 XOR INVERT) in IDLE and GAP.
- Reset (resetn = 0 on an edge), including mid-frame: the frame is aborted and the state goes to IDLE.
  - Next-cycle values: sbus_txd = 1 XOR INVERT, frame_done = 0, frame_ready = 0 while resetn = 0.
  - Shadow registers are cleared to 0.
  - A truncated byte on the line is acceptable; the far end reports a frame error.

## Timing

- Handshake at edge of cycle 0. sbus_txd shows the start bit from cycle 1 and holds each bit for exactly CYCLES_PER_BIT cycles.
- Frame = 25 × 12 = 300 bit times = 150000 cycles, occupying cycles 1..150000.
- frame_done is high in cycle 150001 only (first GAP cycle).
- frame_ready reasserts in cycle 150001 + GAP_BITS×CYCLES_PER_BIT = 350001 (if tx_en = 1). The earliest next start bit is the cycle after the next handshake.
- frame_valid held high continuously gives one frame per 350001 cycles. There are no back-to-back frames without the gap.
- Reset values: frame_ready = 0 during reset, 1 in the first cycle after resetn rises if tx_en = 1. sbus_txd idle. frame_done = 0.
- Latency from handshake to first line transition: 1 cycle.

## Test plan

- Idle/reset: resetn low 2 cycles, INVERT = 0 → sbus_txd = 1, frame_done = 0. frame_ready = 1 the cycle after release with tx_en = 1.
- Single frame: ch0 = 0x7FF, other channels 0, flags = 0 → decoded bytes 0x0F, 0xFF, 0x07, then 0x00 ×20, 0x00, 0x00. Parity bits: 0 for 0x0F, 0 for 0xFF, 1 for 0x07. Each byte has 2 stop bits high.
- Cycle timing: handshake at cycle 0 → txd falls at cycle 1, frame_done pulses at cycle 150001 only, frame_ready rises at cycle 350001. Each bit width is exactly 500 cycles.
- Flags and shadowing: flags = 4'b1010, ch_data changed to all-ones during transmission → B23 = 0x0A, and channel bytes reflect the captured values only.
- Loopback: drive sbus_txd into the existing uart_rx with random channels over 4 frames → 100 bytes received, each uart_rx_data = {2'b11, ^d, d}, no parity or frame errors.
- Abort/enable: resetn pulsed low at cycle 30000 → txd idle next cycle, no frame_done. tx_en low at cycle 100 of a frame → frame completes, frame_ready stays 0 until tx_en returns. INVERT = 1 → every line level is complemented.
